// File: rtl/loop_step_sequencer.sv
// Walking-one sequencer for the registered-flop -> inverter loop datapath.
// Drives one pattern per step, captures the loop output SAMPLE_LAT clocks later and scores it.
module loop_step_sequencer #(
  parameter int WIDTH      = 8,
  parameter int SAMPLE_LAT = 3,
  parameter int NUM_STEPS  = 8,
  localparam int CNT_W     = $clog2(NUM_STEPS + 1),
  localparam int IDX_W     = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  output logic [WIDTH-1:0] d_out,
  input  logic [WIDTH-1:0] q_in,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [CNT_W-1:0] err_cnt,
  output logic [IDX_W-1:0] first_err,
  output logic [IDX_W-1:0] step_idx
);

  localparam int WAIT_W = 4;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam logic [WIDTH-1:0]  ONE       = WIDTH'(1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(SAMPLE_LAT - 1);
  localparam logic [IDX_W-1:0]  STEP_LAST = IDX_W'(NUM_STEPS - 1);

  logic [1:0]        state_q, state_d;
  logic [WIDTH-1:0]  d_out_q, d_out_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              pass_q, pass_d;
  logic [CNT_W-1:0]  err_cnt_q, err_cnt_d;
  logic [IDX_W-1:0]  first_err_q, first_err_d;
  logic [IDX_W-1:0]  step_idx_q, step_idx_d;
  logic [WAIT_W-1:0] wait_q, wait_d;

  logic              capture;
  logic              mismatch;
  logic              last_step;
  logic [IDX_W-1:0]  next_idx;

  // The 4-state compare makes an unsettled (X) loop output count as a failure in simulation.
  assign capture   = (wait_q == WAIT_LAST);
  assign mismatch  = (q_in !== ~d_out_q);
  assign last_step = (step_idx_q == STEP_LAST);
  assign next_idx  = step_idx_q + 1'b1;

  always_comb begin
    state_d     = state_q;
    d_out_d     = d_out_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    pass_d      = pass_q;
    err_cnt_d   = err_cnt_q;
    first_err_d = first_err_q;
    step_idx_d  = step_idx_q;
    wait_d      = wait_q;

    case (state_q)
      ST_IDLE: begin
        if (start && !abort) begin
          state_d     = ST_RUN;
          d_out_d     = ONE;
          busy_d      = 1'b1;
          pass_d      = 1'b0;
          err_cnt_d   = '0;
          first_err_d = '0;
          step_idx_d  = '0;
          wait_d      = '0;
        end
      end

      ST_RUN: begin
        // Abort outranks a coinciding capture, so that step's result is dropped.
        if (abort) begin
          state_d = ST_IDLE;
          d_out_d = '0;
          busy_d  = 1'b0;
          pass_d  = 1'b0;
        end else if (capture) begin
          if (mismatch) begin
            err_cnt_d = err_cnt_q + 1'b1;
            if (err_cnt_q == '0) begin
              first_err_d = step_idx_q;
            end
          end
          if (last_step) begin
            state_d = ST_DONE;
            d_out_d = '0;
            busy_d  = 1'b0;
          end else begin
            step_idx_d = next_idx;
            d_out_d    = ONE << next_idx;
            wait_d     = '0;
          end
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
        if (abort) begin
          d_out_d = '0;
          pass_d  = 1'b0;
        end else begin
          done_d = 1'b1;
          pass_d = (err_cnt_q == '0);
        end
      end

      default: begin
        state_d = ST_IDLE;
        d_out_d = '0;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      d_out_q     <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
      err_cnt_q   <= '0;
      first_err_q <= '0;
      step_idx_q  <= '0;
      wait_q      <= '0;
    end else begin
      state_q     <= state_d;
      d_out_q     <= d_out_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      pass_q      <= pass_d;
      err_cnt_q   <= err_cnt_d;
      first_err_q <= first_err_d;
      step_idx_q  <= step_idx_d;
      wait_q      <= wait_d;
    end
  end

  assign d_out     = d_out_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign pass      = pass_q;
  assign err_cnt   = err_cnt_q;
  assign first_err = first_err_q;
  assign step_idx  = step_idx_q;

endmodule

// File: tb/tb_loop_step_sequencer.sv
// Bench for loop_step_sequencer: two instances (SAMPLE_LAT 3 and 1) each driving a modelled
// flop (1 time unit) -> inverter (3 time units) loop, with injectable stuck-at faults on q_in.
module tb_loop_step_sequencer;

  typedef struct {
    bit         use_b;
    logic [7:0] or_mask;
    logic [7:0] and_mask;
    int         abort_obs;
    int         exp_err;
    int         exp_first;
    bit         exp_pass;
    bit         exp_done;
    int         exp_len;
  } vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, start, abort, use_b;
  logic [7:0] or_mask, and_mask;
  logic       start_a, abort_a, start_b, abort_b;

  logic [7:0] d_out_a, d_out_b, q_in_a, q_in_b;
  logic [7:0] flop_a = 8'h00, flop_b = 8'h00;
  logic [7:0] q_inv_a = 8'hff, q_inv_b = 8'hff;
  logic [7:0] samp_a, samp_b;
  logic       busy_a, done_a, pass_a, busy_b, done_b, pass_b;
  logic [3:0] err_a, err_b;
  logic [2:0] first_a, first_b, step_a, step_b;

  logic [7:0] o_d_out;
  logic       o_busy, o_done, o_pass;
  logic [3:0] o_err;
  logic [2:0] o_first, o_step;

  int checks = 0;
  int errors = 0;
  vec_t vecs[8];
  vec_t clean_vec;

  assign start_a = start & ~use_b;
  assign abort_a = abort & ~use_b;
  assign start_b = start & use_b;
  assign abort_b = abort & use_b;

  loop_step_sequencer #(.WIDTH(8), .SAMPLE_LAT(3), .NUM_STEPS(8)) dut_a (
    .clk(clk), .rst(rst), .start(start_a), .abort(abort_a),
    .d_out(d_out_a), .q_in(q_in_a), .busy(busy_a), .done(done_a), .pass(pass_a),
    .err_cnt(err_a), .first_err(first_a), .step_idx(step_a)
  );

  loop_step_sequencer #(.WIDTH(8), .SAMPLE_LAT(1), .NUM_STEPS(8)) dut_b (
    .clk(clk), .rst(rst), .start(start_b), .abort(abort_b),
    .d_out(d_out_b), .q_in(q_in_b), .busy(busy_b), .done(done_b), .pass(pass_b),
    .err_cnt(err_b), .first_err(first_b), .step_idx(step_b)
  );

  // Loop datapath models: clock-to-Q of 1, inverter delay of 3, faults applied on the way back.
  always @(posedge clk) begin
    samp_a = d_out_a;
    #1 flop_a = samp_a;
  end

  always @(posedge clk) begin
    samp_b = d_out_b;
    #1 flop_b = samp_b;
  end

  always @(flop_a) begin
    #3 q_inv_a = ~flop_a;
  end

  always @(flop_b) begin
    #3 q_inv_b = ~flop_b;
  end

  assign q_in_a = (q_inv_a | or_mask) & and_mask;
  assign q_in_b = (q_inv_b | or_mask) & and_mask;

  always_comb begin
    o_d_out = use_b ? d_out_b : d_out_a;
    o_busy  = use_b ? busy_b  : busy_a;
    o_done  = use_b ? done_b  : done_a;
    o_pass  = use_b ? pass_b  : pass_a;
    o_err   = use_b ? err_b   : err_a;
    o_first = use_b ? first_b : first_a;
    o_step  = use_b ? step_b  : step_a;
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // One run from a start pulse; observation k is taken at the negedge after edge k (start = edge 0).
  task automatic applyStimulus(input vec_t v);
    int  len;
    int  lat;
    bit  seq_ok;
    bit  aborted;
    logic [7:0] exp_d;
    use_b    = v.use_b;
    or_mask  = v.or_mask;
    and_mask = v.and_mask;
    lat      = v.use_b ? 1 : 3;
    len      = -1;
    seq_ok   = 1'b1;
    aborted  = 1'b0;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      if (!aborted && v.abort_obs >= 0 && k == v.abort_obs) begin
        abort = 1'b1;
        @(posedge clk);
        #1 abort = 1'b0;
        @(negedge clk);
        k++;
        aborted = 1'b1;
        checkOutput("abort_busy", 32'(o_busy), 32'(0));
        checkOutput("abort_d_out", 32'(o_d_out), 32'(0));
        checkOutput("abort_done", 32'(o_done), 32'(0));
      end
      if (o_done && len < 0) len = k;
      if (v.abort_obs < 0 && k <= v.exp_len) begin
        exp_d = (k < 8 * lat) ? (8'h01 << (k / lat)) : 8'h00;
        if (o_d_out !== exp_d || o_busy !== (k < 8 * lat)) seq_ok = 1'b0;
      end
    end
    checkOutput("err_cnt", 32'(o_err), 32'(v.exp_err));
    checkOutput("first_err", 32'(o_first), 32'(v.exp_first));
    checkOutput("pass", 32'(o_pass), 32'(v.exp_pass));
    checkOutput("done_seen", 32'(len >= 0), 32'(v.exp_done));
    if (v.abort_obs < 0) begin
      checkOutput("run_length", 32'(len), 32'(v.exp_len));
      checkOutput("d_out_busy_sequence", 32'(seq_ok), 32'(1));
    end
    or_mask  = 8'h00;
    and_mask = 8'hff;
  endtask

  initial begin
    int  done_cnt;
    int  len;
    bit  hit;

    //             use_b or_mask  and_mask abort err first pass done len
    vecs[0] = '{1'b0, 8'h00, 8'hff, -1, 0, 0, 1'b1, 1'b1, 25};
    vecs[1] = '{1'b0, 8'h04, 8'hff, -1, 1, 2, 1'b0, 1'b1, 25};
    vecs[2] = '{1'b0, 8'h80, 8'hff, -1, 1, 7, 1'b0, 1'b1, 25};
    vecs[3] = '{1'b0, 8'h00, 8'hfe, -1, 7, 1, 1'b0, 1'b1, 25};
    vecs[4] = '{1'b1, 8'h00, 8'hff, -1, 8, 0, 1'b0, 1'b1, 9};
    vecs[5] = '{1'b0, 8'h00, 8'hff,  9, 0, 0, 1'b0, 1'b0, 0};
    vecs[6] = '{1'b0, 8'h00, 8'hff, -1, 0, 0, 1'b1, 1'b1, 25};
    vecs[7] = '{1'b0, 8'h04, 8'hff,  8, 0, 0, 1'b0, 1'b0, 0};
    clean_vec = '{1'b0, 8'h00, 8'hff, -1, 0, 0, 1'b1, 1'b1, 25};

    rst      = 1'b1;
    start    = 1'b0;
    abort    = 1'b0;
    use_b    = 1'b0;
    or_mask  = 8'h00;
    and_mask = 8'hff;

    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("reset_d_out", 32'(o_d_out), 32'(0));
    checkOutput("reset_busy", 32'(o_busy), 32'(0));
    checkOutput("reset_done", 32'(o_done), 32'(0));
    checkOutput("reset_pass", 32'(o_pass), 32'(0));
    checkOutput("reset_err_cnt", 32'(o_err), 32'(0));
    checkOutput("reset_first_err", 32'(o_first), 32'(0));
    checkOutput("reset_step_idx", 32'(o_step), 32'(0));
    rst = 1'b0;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 8; i++) begin
      $display("[TB] vector %0d", i);
      applyStimulus(vecs[i]);
    end

    $display("[TB] start held through a run");
    use_b = 1'b0;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    done_cnt = 0;
    len = -1;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      if (o_done) begin
        done_cnt++;
        if (len < 0) len = k;
        start = 1'b0;
      end
    end
    start = 1'b0;
    checkOutput("held_start_done_count", 32'(done_cnt), 32'(1));
    checkOutput("held_start_run_length", 32'(len), 32'(25));
    checkOutput("held_start_err_cnt", 32'(o_err), 32'(0));
    checkOutput("held_start_pass", 32'(o_pass), 32'(1));

    $display("[TB] start and abort together in idle");
    @(negedge clk);
    start = 1'b1;
    abort = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    abort = 1'b0;
    @(negedge clk);
    checkOutput("start_abort_busy", 32'(o_busy), 32'(0));
    checkOutput("start_abort_step_idx", 32'(o_step), 32'(7));
    checkOutput("start_abort_pass", 32'(o_pass), 32'(1));
    repeat (3) @(negedge clk);
    checkOutput("start_abort_still_idle", 32'(o_busy), 32'(0));

    $display("[TB] reset mid-run at step 5");
    or_mask = 8'h04;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    hit = 1'b0;
    for (int k = 0; k < 40 && !hit; k++) begin
      @(negedge clk);
      if (o_step == 3'd5) hit = 1'b1;
    end
    checkOutput("rst_reached_step5", 32'(hit), 32'(1));
    checkOutput("rst_err_before", 32'(o_err), 32'(1));
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    checkOutput("rst_mid_d_out", 32'(o_d_out), 32'(0));
    checkOutput("rst_mid_busy", 32'(o_busy), 32'(0));
    checkOutput("rst_mid_done", 32'(o_done), 32'(0));
    checkOutput("rst_mid_pass", 32'(o_pass), 32'(0));
    checkOutput("rst_mid_err_cnt", 32'(o_err), 32'(0));
    checkOutput("rst_mid_first_err", 32'(o_first), 32'(0));
    checkOutput("rst_mid_step_idx", 32'(o_step), 32'(0));
    done_cnt = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (o_done) done_cnt++;
    end
    checkOutput("rst_mid_no_done", 32'(done_cnt), 32'(0));
    or_mask = 8'h00;

    $display("[TB] fresh run after reset");
    applyStimulus(clean_vec);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
